// File: rtl/axis_sha3_padder.sv
// rtl/axis_sha3_padder.sv - AXI-Stream byte packer and SHA3 padder feeding rate-sized Keccak absorb blocks
module axis_sha3_padder #(
  parameter int WIDTH    = 16,
  parameter int RATE_MAX = 1152
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [WIDTH-1:0]     S_TDATA,
  input  logic [WIDTH/8-1:0]   S_TKEEP,
  input  logic [1:0]           S_TUSER,
  input  logic                 S_TLAST,
  input  logic                 S_TVALID,
  output logic                 S_TREADY,
  output logic [RATE_MAX-1:0]  BLK_DATA,
  output logic [7:0]           BLK_RATE,
  output logic [1:0]           BLK_MODE,
  output logic                 BLK_LAST,
  output logic                 BLK_VALID,
  input  logic                 BLK_READY,
  output logic                 ERR
);
  localparam int KEEP_W = WIDTH / 8;
  localparam int NBYTES = RATE_MAX / 8;

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t                state_q, state_d;
  logic [RATE_MAX-1:0]   blk_buf, fill_buf, pad_buf;
  logic [7:0]            byte_cnt, new_cnt, cur_rate, rate_q;
  logic [1:0]            mode_q, cur_mode;
  logic                  msg_open, pad_pending, last_q, err_q;
  logic [KEEP_W-1:0]     inv_keep, eff_keep;
  logic [3:0]            nbytes;
  logic                  contig, beat_err, fire, blk_full, blk_done;

  function automatic logic [7:0] rate_of(input logic [1:0] m);
    case (m)
      2'd0:    return 8'd144;
      2'd1:    return 8'd136;
      2'd2:    return 8'd104;
      default: return 8'd72;
    endcase
  endfunction

  // Beat datapath: sanitise TKEEP, place bytes at byte_cnt, apply pad when the message ends short of R.
  always_comb begin
    cur_mode = msg_open ? mode_q : S_TUSER;
    cur_rate = rate_of(cur_mode);
    inv_keep = ~S_TKEEP;
    contig   = (inv_keep & (inv_keep + KEEP_W'(1))) == '0;
    beat_err = S_TLAST ? !contig : (S_TKEEP != '1);
    if (!S_TLAST && S_TKEEP == '0)
      eff_keep = '0;
    else if (beat_err)
      eff_keep = '1;
    else
      eff_keep = S_TKEEP;
    nbytes = '0;
    for (int i = 0; i < KEEP_W; i++)
      nbytes = nbytes + 4'(eff_keep[i]);
    new_cnt  = byte_cnt + {4'd0, nbytes};
    fire     = S_TVALID && S_TREADY;
    blk_full = new_cnt >= cur_rate;
    blk_done = fire && (blk_full || S_TLAST);
    fill_buf = blk_buf;
    for (int i = 0; i < KEEP_W; i++)
      if (i < int'(nbytes) && int'(byte_cnt) + i < NBYTES)
        fill_buf[8*(int'(byte_cnt)+i) +: 8] = S_TDATA[WIDTH-1-8*i -: 8];
    if (S_TLAST && !blk_full) begin
      fill_buf[8*int'(new_cnt) +: 8]       = fill_buf[8*int'(new_cnt) +: 8] ^ 8'h06;
      fill_buf[8*(int'(cur_rate)-1) +: 8]  = fill_buf[8*(int'(cur_rate)-1) +: 8] ^ 8'h80;
    end
  end

  always_comb begin
    rate_q  = rate_of(mode_q);
    pad_buf = '0;
    pad_buf[7:0] = 8'h06;
    pad_buf[8*(int'(rate_q)-1) +: 8] = 8'h80;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (blk_done) state_d = EMIT;
      EMIT:    if (BLK_READY) state_d = pad_pending ? EXTRA : FILL;
      EXTRA:   if (BLK_READY) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Ready is also gated by ARESET itself so no beat can look accepted while reset is held.
  always_comb begin
    S_TREADY  = (state_q == FILL) && !ARESET;
    BLK_VALID = (state_q != FILL);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      blk_buf     <= '0;
      byte_cnt    <= '0;
      mode_q      <= 2'd3;
      msg_open    <= 1'b0;
      pad_pending <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        FILL: if (fire) begin
          blk_buf  <= fill_buf;
          byte_cnt <= new_cnt;
          mode_q   <= cur_mode;
          msg_open <= !S_TLAST;
          err_q    <= err_q | beat_err;
          if (blk_done) begin
            last_q      <= S_TLAST && !blk_full;
            pad_pending <= S_TLAST && blk_full;
          end
        end
        EMIT: if (BLK_READY) begin
          byte_cnt <= '0;
          if (pad_pending) begin
            blk_buf     <= pad_buf;
            last_q      <= 1'b1;
            pad_pending <= 1'b0;
          end else begin
            blk_buf <= '0;
            last_q  <= 1'b0;
          end
        end
        EXTRA: if (BLK_READY) begin
          blk_buf  <= '0;
          byte_cnt <= '0;
          last_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign BLK_DATA = blk_buf;
  assign BLK_RATE = rate_q;
  assign BLK_MODE = mode_q;
  assign BLK_LAST = last_q;
  assign ERR      = err_q;
endmodule

// File: tb/tb_axis_sha3_padder.sv
// tb/tb_axis_sha3_padder.sv - directed bench for axis_sha3_padder at 16-bit and 64-bit stream widths
module tb_axis_sha3_padder;
  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  logic [15:0]   s_tdata;
  logic [1:0]    s_tkeep, s_tuser;
  logic          s_tlast, s_tvalid, s_tready;
  logic [1151:0] blk_data;
  logic [7:0]    blk_rate;
  logic [1:0]    blk_mode;
  logic          blk_last, blk_valid, blk_ready, err;

  logic [63:0]   d_tdata;
  logic [7:0]    d_tkeep;
  logic [1:0]    d_tuser;
  logic          d_tlast, d_tvalid, d_tready;
  logic [1151:0] d_blk_data;
  logic [7:0]    d_blk_rate;
  logic [1:0]    d_blk_mode;
  logic          d_blk_last, d_blk_valid, d_blk_ready, d_err;

  axis_sha3_padder #(.WIDTH(16), .RATE_MAX(1152)) dut16 (
    .ACLK(ACLK), .ARESET(ARESET), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep), .S_TUSER(s_tuser),
    .S_TLAST(s_tlast), .S_TVALID(s_tvalid), .S_TREADY(s_tready), .BLK_DATA(blk_data),
    .BLK_RATE(blk_rate), .BLK_MODE(blk_mode), .BLK_LAST(blk_last), .BLK_VALID(blk_valid),
    .BLK_READY(blk_ready), .ERR(err));

  axis_sha3_padder #(.WIDTH(64), .RATE_MAX(1152)) dut64 (
    .ACLK(ACLK), .ARESET(ARESET), .S_TDATA(d_tdata), .S_TKEEP(d_tkeep), .S_TUSER(d_tuser),
    .S_TLAST(d_tlast), .S_TVALID(d_tvalid), .S_TREADY(d_tready), .BLK_DATA(d_blk_data),
    .BLK_RATE(d_blk_rate), .BLK_MODE(d_blk_mode), .BLK_LAST(d_blk_last), .BLK_VALID(d_blk_valid),
    .BLK_READY(d_blk_ready), .ERR(d_err));

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]    msg [0:511];
  int            msg_len;
  logic [1151:0] exp_blk [0:7];
  logic          exp_last [0:7];
  int            n_exp;

  function automatic int rate_of(input int m);
    case (m)
      0: return 144;
      1: return 136;
      2: return 104;
      default: return 72;
    endcase
  endfunction

  // Reference SHA3 pad10*1 with domain bits 0x06: whole rate chunks, then a final padded block.
  task automatic build_exp(input int mode);
    int r, pos;
    logic [1151:0] tmp;
    r = rate_of(mode); pos = 0; n_exp = 0;
    while (msg_len - pos >= r) begin
      tmp = '0;
      for (int k = 0; k < r; k++) tmp[8*k +: 8] = msg[pos+k];
      exp_blk[n_exp] = tmp; exp_last[n_exp] = 1'b0; n_exp++; pos += r;
    end
    tmp = '0;
    for (int k = 0; k < msg_len - pos; k++) tmp[8*k +: 8] = msg[pos+k];
    tmp[8*(msg_len-pos) +: 8] = tmp[8*(msg_len-pos) +: 8] ^ 8'h06;
    tmp[8*(r-1) +: 8] = tmp[8*(r-1) +: 8] ^ 8'h80;
    exp_blk[n_exp] = tmp; exp_last[n_exp] = 1'b1; n_exp++;
  endtask

  task automatic send16(input logic [15:0] d, input logic [1:0] k, input logic [1:0] u, input logic l);
    int t;
    s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1; t = 0;
    while (s_tready !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
    if (t >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout tready=%b required 1", s_tready);
    end
    @(negedge ACLK);
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_msg16(input int mode);
    if (msg_len == 0) send16(16'h0000, 2'b00, 2'(mode), 1'b1);
    else
      for (int i = 0; i < msg_len; i += 2) begin
        if (i + 1 < msg_len) send16({msg[i], msg[i+1]}, 2'b11, 2'(mode), i + 2 >= msg_len);
        else                 send16({msg[i], 8'h00}, 2'b10, 2'(mode), 1'b1);
      end
  endtask

  task automatic recv_blocks(input int mode, input int stall);
    int t, bad_k;
    logic [1151:0] held;
    for (int b = 0; b < n_exp; b++) begin
      t = 0;
      while (blk_valid !== 1'b1 && t < 3000) begin @(negedge ACLK); t++; end
      n_cmp++;
      if (t >= 3000) begin
        n_bad++; $display("FAIL blk_valid_timeout block=%0d got=%b required 1", b, blk_valid);
        return;
      end
      n_cmp++;
      if (blk_data !== exp_blk[b]) begin
        n_bad++; bad_k = 0;
        for (int k = 143; k >= 0; k--) if (blk_data[8*k +: 8] !== exp_blk[b][8*k +: 8]) bad_k = k;
        $display("FAIL blk_data block=%0d byte=%0d got=%h required=%h", b, bad_k,
                 blk_data[8*bad_k +: 8], exp_blk[b][8*bad_k +: 8]);
      end
      n_cmp++;
      if (blk_last !== exp_last[b]) begin
        n_bad++; $display("FAIL blk_last block=%0d got=%b required=%b", b, blk_last, exp_last[b]);
      end
      n_cmp++;
      if (blk_rate !== 8'(rate_of(mode)) || blk_mode !== 2'(mode)) begin
        n_bad++; $display("FAIL blk_rate_mode block=%0d got=%0d/%0d required=%0d/%0d",
                          b, blk_rate, blk_mode, rate_of(mode), mode);
      end
      for (int s = 0; s < stall; s++) begin
        held = blk_data;
        @(negedge ACLK);
        n_cmp++;
        if (blk_data !== held || s_tready !== 1'b0 || blk_valid !== 1'b1) begin
          n_bad++; $display("FAIL stall_hold block=%0d cycle=%0d tready=%b valid=%b required 0/1 and stable data",
                            b, s, s_tready, blk_valid);
        end
      end
      blk_ready = 1'b1;
      @(negedge ACLK);
      blk_ready = 1'b0;
    end
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if (blk_valid !== 1'b0) begin
      n_bad++; $display("FAIL extra_block valid=%b required 0", blk_valid);
    end
  endtask

  task automatic test_reset;
    @(negedge ACLK);
    n_cmp++;
    if (s_tready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl tready/valid/last/err=%b%b%b%b required 0000",
                        s_tready, blk_valid, blk_last, err);
    end
    n_cmp++;
    if (blk_data !== '0 || blk_rate !== 8'd72 || blk_mode !== 2'd3) begin
      n_bad++; $display("FAIL reset_blk rate=%0d mode=%0d data_zero=%b required 72/3/1",
                        blk_rate, blk_mode, blk_data == '0);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release tready=%b required 1", s_tready);
    end
  endtask

  task automatic test_empty;
    msg_len = 0; build_exp(3);
    send_msg16(3);
    recv_blocks(3, 0);
  endtask

  task automatic test_abc;
    msg_len = 3; msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    build_exp(1);
    send_msg16(1);
    n_cmp++;
    if (blk_valid !== 1'b1) begin
      n_bad++; $display("FAIL abc_latency valid=%b required 1", blk_valid);
    end
    n_cmp++;
    if (blk_data[31:0] !== 32'h06636261 || blk_data[135*8 +: 8] !== 8'h80) begin
      n_bad++; $display("FAIL abc_bytes got=%h/%h required 06636261/80", blk_data[31:0], blk_data[135*8 +: 8]);
    end
    recv_blocks(1, 0);
  endtask

  task automatic test_boundary_71_72;
    msg_len = 71;
    for (int i = 0; i < 72; i++) msg[i] = 8'(i + 1);
    build_exp(3);
    send_msg16(3);
    n_cmp++;
    if (blk_data[71*8 +: 8] !== 8'h86 || blk_last !== 1'b1) begin
      n_bad++; $display("FAIL len71_byte71 got=%h last=%b required 86/1", blk_data[71*8 +: 8], blk_last);
    end
    recv_blocks(3, 0);
    msg_len = 72; build_exp(3);
    fork
      send_msg16(3);
      recv_blocks(3, 0);
    join
  endtask

  task automatic test_stall;
    msg_len = 300;
    for (int i = 0; i < 300; i++) msg[i] = 8'hA5;
    build_exp(0);
    fork
      send_msg16(0);
      recv_blocks(0, 5);
    join
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 20; i++) send16(16'hEEEE, 2'b11, 2'd0, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    repeat (5) @(negedge ACLK);
    n_cmp++;
    if (blk_valid !== 1'b0 || blk_data !== '0) begin
      n_bad++; $display("FAIL reset_mid valid=%b data_zero=%b required 0/1", blk_valid, blk_data == '0);
    end
    test_abc();
  endtask

  task automatic test_err64;
    logic [1151:0] want;
    want = '0;
    want[63:0]   = 64'h0807060504030201;
    want[127:64] = 64'h1817161514131211;
    want[16*8 +: 8] = 8'h06;
    want[71*8 +: 8] = 8'h80;
    d_tdata = 64'h0102030405060708; d_tkeep = 8'hF0; d_tuser = 2'd3; d_tlast = 1'b0; d_tvalid = 1'b1;
    @(negedge ACLK);
    d_tdata = 64'h1112131415161718; d_tkeep = 8'hFF; d_tuser = 2'd0; d_tlast = 1'b1;
    n_cmp++;
    if (d_err !== 1'b1) begin
      n_bad++; $display("FAIL err64_set err=%b required 1", d_err);
    end
    @(negedge ACLK);
    d_tvalid = 1'b0; d_tlast = 1'b0;
    n_cmp++;
    if (d_blk_valid !== 1'b1 || d_blk_last !== 1'b1 || d_blk_rate !== 8'd72) begin
      n_bad++; $display("FAIL err64_blk valid/last/rate=%b/%b/%0d required 1/1/72", d_blk_valid, d_blk_last, d_blk_rate);
    end
    n_cmp++;
    if (d_blk_data !== want) begin
      n_bad++; $display("FAIL err64_data low=%h byte16=%h required %h/06", d_blk_data[127:0],
                        d_blk_data[16*8 +: 8], want[127:0]);
    end
    d_blk_ready = 1'b1;
    @(negedge ACLK);
    d_blk_ready = 1'b0;
    repeat (2) @(negedge ACLK);
    n_cmp++;
    if (d_err !== 1'b1 || d_blk_valid !== 1'b0) begin
      n_bad++; $display("FAIL err64_sticky err=%b valid=%b required 1/0", d_err, d_blk_valid);
    end
  endtask

  initial begin
    s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0; blk_ready = 1'b0;
    d_tdata = '0; d_tkeep = '0; d_tuser = '0; d_tlast = 1'b0; d_tvalid = 1'b0; d_blk_ready = 1'b0;
    test_reset();
    test_empty();
    test_abc();
    test_boundary_71_72();
    test_stall();
    test_reset_mid();
    test_err64();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
